// File: rtl/picw_pkg.sv
// Shared types and helpers for the PIC writer word accumulator.
// State encoding, slice-count helper and parameter sanity predicate.
package picw_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_ADD    = 2'd2,
      ST_DONE   = 2'd3
   } picw_acc_state_t;

   function automatic int nslice(input int acc_w, input int slice_w);
      return acc_w / slice_w;
   endfunction

   // Accumulator must hold a whole word, split evenly into slices, and carry a checksum byte.
   function automatic bit params_ok(input int data_w, input int acc_w, input int slice_w);
      return (slice_w > 0) && (acc_w % slice_w == 0) && (acc_w >= data_w) && (acc_w >= 8);
   endfunction

endpackage

// File: rtl/picw_word_accumulator_if.sv
// Handshake and result bus of the word accumulator.
// The master side feeds words and consumes results; the slave side is the accumulator.
interface picw_word_accumulator_if #(
   parameter int DATA_W = 14,
   parameter int ACC_W  = 16,
   parameter int CNT_W  = 8
);
   logic              start_i;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  sum_o;
   logic [CNT_W-1:0]  carry_cnt_o;
   logic              busy_o;
   logic [7:0]        chk_o;

   modport master (
      output start_i, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, sum_o, carry_cnt_o, busy_o, chk_o
   );

   modport slave (
      input  start_i, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, sum_o, carry_cnt_o, busy_o, chk_o
   );
endinterface

// File: rtl/picw_slice_add.sv
// Combinational W-bit full adder with carry-in and carry-out.
module picw_slice_add #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
endmodule

// File: rtl/picw_word_accumulator.sv
// Multi-cycle word accumulator: adds SLICE_W bits per clock with a registered carry.
// Optional Intel HEX checksum output enabled by defining PICW_HEXCHK_EN.
module picw_word_accumulator
   import picw_pkg::*;
#(
   parameter int DATA_W  = 14,
   parameter int ACC_W   = 16,
   parameter int SLICE_W = 4,
   parameter int CNT_W   = 8
) (
   input logic                      clk_x,
   input logic                      rst_x,
   picw_word_accumulator_if.slave   bus
);
   localparam int NSLICE = nslice(ACC_W, SLICE_W);
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   if (!params_ok(DATA_W, ACC_W, SLICE_W)) begin : g_bad_params
      $error("picw_word_accumulator: ACC_W must be >= DATA_W, >= 8 and a multiple of SLICE_W");
   end

   picw_acc_state_t  state_reg, state_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic             carry_reg, carry_next;
   logic [ACC_W-1:0] word_reg, word_next;
   logic             last_reg, last_next;
   logic [ACC_W-1:0] sum_reg, sum_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
   logic               slice_cout;
   logic               clear_frame;
   logic               done_entry;

   // One adder shared by all slices; the slice index steers its operands.
   assign slice_a = sum_reg[idx_reg*SLICE_W +: SLICE_W];
   assign slice_b = word_reg[idx_reg*SLICE_W +: SLICE_W];

   picw_slice_add #(.W(SLICE_W)) u_slice_add (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_reg),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   assign clear_frame = bus.start_i &&
                        ((state_reg == ST_IDLE) || (state_reg == ST_DONE && bus.out_ready));
   assign done_entry  = (state_reg == ST_ADD) && (idx_reg == LAST_IDX) && last_reg;

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      carry_next = carry_reg;
      word_next  = word_reg;
      last_next  = last_reg;
      sum_next   = sum_reg;
      cnt_next   = cnt_reg;

      case (state_reg)
         ST_IDLE: begin
            if (bus.start_i) state_next = ST_ACCEPT;
         end
         ST_ACCEPT: begin
            if (bus.in_valid) begin
               word_next  = ACC_W'(bus.in_data);
               last_next  = bus.in_last;
               idx_next   = '0;
               carry_next = 1'b0;
               state_next = ST_ADD;
            end
         end
         ST_ADD: begin
            sum_next[idx_reg*SLICE_W +: SLICE_W] = slice_sum;
            carry_next = slice_cout;
            if (idx_reg == LAST_IDX) begin
               if (slice_cout && (cnt_reg != '1)) cnt_next = cnt_reg + 1'b1;
               idx_next   = '0;
               state_next = last_reg ? ST_DONE : ST_ACCEPT;
            end else begin
               idx_next = idx_reg + 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_next = bus.start_i ? ST_ACCEPT : ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase

      if (clear_frame) begin
         sum_next   = '0;
         cnt_next   = '0;
         carry_next = 1'b0;
         last_next  = 1'b0;
         idx_next   = '0;
      end
   end

   always_ff @(posedge clk_x) begin
      if (rst_x) begin
         state_reg <= ST_IDLE;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
         word_reg  <= '0;
         last_reg  <= 1'b0;
         sum_reg   <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         carry_reg <= carry_next;
         word_reg  <= word_next;
         last_reg  <= last_next;
         sum_reg   <= sum_next;
         cnt_reg   <= cnt_next;
      end
   end

`ifdef PICW_HEXCHK_EN
   logic [7:0] chk_reg, chk_next;

   // Two's complement of the low byte, captured from the final slice result.
   always_comb begin
      chk_next = chk_reg;
      if (clear_frame)     chk_next = 8'h00;
      else if (done_entry) chk_next = 8'h00 - sum_next[7:0];
   end

   always_ff @(posedge clk_x) begin
      if (rst_x) chk_reg <= 8'h00;
      else       chk_reg <= chk_next;
   end

   assign bus.chk_o = chk_reg;
`else
   assign bus.chk_o = 8'h00;
`endif

   assign bus.in_ready    = (state_reg == ST_ACCEPT);
   assign bus.out_valid   = (state_reg == ST_DONE);
   assign bus.busy_o      = (state_reg != ST_IDLE);
   assign bus.sum_o       = sum_reg;
   assign bus.carry_cnt_o = cnt_reg;
endmodule

// File: tb/tb_picw_word_accumulator.sv
// Scoreboard testbench for picw_word_accumulator with directed frames.
// Checksum expectations follow PICW_HEXCHK_EN.
module tb_picw_word_accumulator;
   import picw_pkg::*;

`ifdef PICW_HEXCHK_EN
   localparam bit HEX_EN = 1'b1;
`else
   localparam bit HEX_EN = 1'b0;
`endif

   typedef struct packed {
      logic [15:0] sum;
      logic [7:0]  cnt;
      logic [7:0]  chk;
   } exp_t;

   logic clk_x = 1'b0;
   logic rst_x = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   picw_word_accumulator_if #(.DATA_W(14), .ACC_W(16), .CNT_W(8)) bus ();

   picw_word_accumulator #(
      .DATA_W(14), .ACC_W(16), .SLICE_W(4), .CNT_W(8)
   ) dut (
      .clk_x (clk_x),
      .rst_x (rst_x),
      .bus   (bus)
   );

   always #5 clk_x = ~clk_x;

   function automatic logic [7:0] xchk(input logic [7:0] hand);
      return HEX_EN ? hand : 8'h00;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"},  32'(bus.in_ready), 0);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      check({tag, "_busy"},      32'(bus.busy_o), 0);
      check({tag, "_sum"},       32'(bus.sum_o), 0);
      check({tag, "_cnt"},       32'(bus.carry_cnt_o), 0);
      check({tag, "_chk"},       32'(bus.chk_o), 0);
   endtask

   // Monitor: every result handed over is compared with the oldest expectation.
   always @(negedge clk_x) begin
      if (!rst_x && bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            $display("result: sum=0x%04h cnt=%0d chk=0x%02h (exp sum=0x%04h cnt=%0d chk=0x%02h)",
                     bus.sum_o, bus.carry_cnt_o, bus.chk_o, e.sum, e.cnt, e.chk);
            check("res_sum", 32'(bus.sum_o), 32'(e.sum));
            check("res_cnt", 32'(bus.carry_cnt_o), 32'(e.cnt));
            check("res_chk", 32'(bus.chk_o), 32'(e.chk));
         end
      end
   end

   task automatic start_frame();
      @(posedge clk_x); #1;
      bus.start_i = 1'b1;
      @(posedge clk_x); #1;
      bus.start_i = 1'b0;
   endtask

   // Offers one word, then checks the 4-cycle ADD gap and what follows it.
   task automatic send_word(input logic [13:0] w, input logic last, input bit pulse_start);
      int t = 0;
      while (!bus.in_ready && t < 20) begin
         @(posedge clk_x); #1;
         t++;
      end
      check("in_ready_wait", 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      bus.in_last  = last;
      @(posedge clk_x); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("add_in_ready_low", 32'(bus.in_ready), 0);
         bus.start_i = pulse_start && (k == 1);
         @(posedge clk_x); #1;
      end
      bus.start_i = 1'b0;
      if (last) check("out_valid_after_add", 32'(bus.out_valid), 1);
      else      check("in_ready_after_add",  32'(bus.in_ready), 1);
   endtask

   initial begin
      bus.start_i   = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge clk_x);
      #1;
      check_all_zero("reset");
      rst_x = 1'b0;

      // Single word
      start_frame();
      sb_q.push_back('{sum: 16'h3FFF, cnt: 8'd0, chk: xchk(8'h01)});
      send_word(14'h3FFF, 1'b1, 1'b0);

      // Five words overflow once: 5*0x3FFF = 0x13FFB
      start_frame();
      sb_q.push_back('{sum: 16'h3FFB, cnt: 8'd1, chk: xchk(8'h05)});
      for (int i = 0; i < 5; i++) send_word(14'h3FFF, (i == 4), 1'b0);

      // Backpressure, with a start pulse during ADD that must be ignored
      start_frame();
      bus.out_ready = 1'b0;
      sb_q.push_back('{sum: 16'h3579, cnt: 8'd0, chk: xchk(8'h87)});
      send_word(14'h1234, 1'b0, 1'b1);
      send_word(14'h2345, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_x);
         check("hold_valid", 32'(bus.out_valid), 1);
         check("hold_sum",   32'(bus.sum_o), 32'h3579);
         check("hold_chk",   32'(bus.chk_o), 32'(xchk(8'h87)));
      end
      bus.out_ready = 1'b1;
      @(posedge clk_x); #1;

      // Checksum frame
      start_frame();
      sb_q.push_back('{sum: 16'h0003, cnt: 8'd0, chk: xchk(8'hFD)});
      send_word(14'h0001, 1'b0, 1'b0);
      send_word(14'h0002, 1'b1, 1'b0);

      // Reset during slice 2 aborts the frame silently
      start_frame();
      bus.in_valid = 1'b1;
      bus.in_data  = 14'h0007;
      bus.in_last  = 1'b1;
      @(posedge clk_x); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      repeat (2) begin
         @(posedge clk_x); #1;
      end
      rst_x = 1'b1;
      @(posedge clk_x); #1;
      check_all_zero("midadd_rst");
      rst_x = 1'b0;
      start_frame();
      sb_q.push_back('{sum: 16'h0005, cnt: 8'd0, chk: xchk(8'hFB)});
      send_word(14'h0005, 1'b1, 1'b0);

      for (int t = 0; t < 20 && sb_q.size() != 0; t++) @(posedge clk_x);
      check("scoreboard_drained", 32'(sb_q.size()), 0);
      @(posedge clk_x);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
